// File: rtl/vector_list_sequencer.sv
// Display-list sequencer: fetches commands from RAM, issues jump/draw to the vector control
// block one per ready, and paces frames. Optional bank double-buffering: VECLIST_DOUBLE_BUFFER_EN.
module vector_list_sequencer #(
   parameter int unsigned ADDR_W       = 10,
   parameter int unsigned FRAME_CYCLES = 833333,
   parameter int unsigned CNT_W        = 20
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   output logic              mem_rd,
`ifdef VECLIST_DOUBLE_BUFFER_EN
   output logic [ADDR_W:0]   mem_addr,
`else
   output logic [ADDR_W-1:0] mem_addr,
`endif
   input  logic [31:0]       mem_data,
   input  logic              ctl_ready,
   output logic [11:0]       x,
   output logic [11:0]       y,
   output logic              jump,
   output logic              draw,
   output logic              frame_start,
   output logic              overrun,
   output logic              bad_list,
`ifdef VECLIST_DOUBLE_BUFFER_EN
   input  logic              clear_flags,
   input  logic              bank_swap_req,
   output logic              bank_active
`else
   input  logic              clear_flags
`endif
);

   localparam logic [1:0]       OP_END     = 2'b10;
   localparam logic [1:0]       OP_NOP     = 2'b11;
   localparam logic [CNT_W-1:0] TIMER_LAST = CNT_W'(FRAME_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DATA, S_ISSUE, S_WAIT} state_t;

   state_t            state, state_nxt, end_nxt;
   logic [ADDR_W-1:0] addr;
   logic [CNT_W-1:0]  timer;
   logic              is_draw;
   logic [1:0]        op;
   logic              addr_last, timer_done;
   logic              start, frame_done, list_end, addr_inc, latch, fire, ovr_set;
   logic              unused_bits;

   assign op          = mem_data[31:30];
   assign addr_last   = (addr == '1);
   assign timer_done  = (timer >= TIMER_LAST);
   assign unused_bits = ^{mem_data[29:28], mem_data[15:12]};

   // Where a finished list goes: hold for the frame period, or restart/stop right away.
   assign end_nxt = !timer_done ? S_WAIT : (enable ? S_FETCH : S_IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (enable) state_nxt = S_FETCH;
         S_FETCH: state_nxt = S_DATA;
         S_DATA: begin
            if (op == OP_END || (op == OP_NOP && addr_last)) state_nxt = end_nxt;
            else if (op == OP_NOP)                           state_nxt = S_FETCH;
            else                                             state_nxt = S_ISSUE;
         end
         S_ISSUE: if (ctl_ready) state_nxt = addr_last ? end_nxt : S_FETCH;
         S_WAIT:  if (timer_done) state_nxt = enable ? S_FETCH : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Control strobes; an address wrap is treated as the end of the list.
   always_comb begin
      start      = 1'b0;
      frame_done = 1'b0;
      list_end   = 1'b0;
      addr_inc   = 1'b0;
      latch      = 1'b0;
      fire       = 1'b0;
      ovr_set    = 1'b0;
      jump       = 1'b0;
      draw       = 1'b0;
      unique case (state)
         S_IDLE: start = enable;
         S_DATA: begin
            if (op == OP_NOP)      addr_inc = 1'b1;
            else if (op != OP_END) latch    = 1'b1;
            list_end = (op == OP_END) || (op == OP_NOP && addr_last);
         end
         S_ISSUE: begin
            fire     = ctl_ready;
            addr_inc = ctl_ready;
            list_end = ctl_ready && addr_last;
         end
         S_WAIT:  frame_done = timer_done;
         default: ;
      endcase
      if (list_end && timer_done) frame_done = 1'b1;
      if (frame_done && enable)   start      = 1'b1;
      ovr_set = (state == S_FETCH || state == S_DATA || state == S_ISSUE) && timer_done && !frame_done;
      jump    = fire && !is_draw && !reset;
      draw    = fire && is_draw && !reset;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         addr        <= '0;
         timer       <= '0;
         x           <= '0;
         y           <= '0;
         is_draw     <= 1'b0;
         mem_rd      <= 1'b0;
         frame_start <= 1'b0;
         overrun     <= 1'b0;
         bad_list    <= 1'b0;
      end else begin
         mem_rd      <= (state_nxt == S_FETCH);
         frame_start <= start;
         if (start || frame_done) begin
            addr  <= '0;
            timer <= '0;
         end else begin
            if (addr_inc) addr <= addr + ADDR_W'(1);
            if (state != S_IDLE && timer != '1) timer <= timer + CNT_W'(1);
         end
         if (latch) begin
            x       <= mem_data[27:16];
            y       <= mem_data[11:0];
            is_draw <= mem_data[30];
         end
         if (ovr_set)          overrun  <= 1'b1;
         else if (clear_flags) overrun  <= 1'b0;
         if (addr_inc && addr_last) bad_list <= 1'b1;
         else if (clear_flags)      bad_list <= 1'b0;
      end
   end

`ifdef VECLIST_DOUBLE_BUFFER_EN
   logic swap_pend;

   // Bank flips only at a frame start; a request seen in that cycle waits one more frame.
   always_ff @(posedge clk) begin
      if (reset) begin
         bank_active <= 1'b0;
         swap_pend   <= 1'b0;
      end else if (start) begin
         bank_active <= bank_active ^ swap_pend;
         swap_pend   <= bank_swap_req;
      end else if (bank_swap_req) begin
         swap_pend   <= 1'b1;
      end
   end

   assign mem_addr = {bank_active, addr};
`else
   assign mem_addr = addr;
`endif

endmodule

// File: tb/tb_vector_list_sequencer.sv
// Bench for vector_list_sequencer: RAM model, event monitor and a list-walking timing model.
module tb_vector_list_sequencer;

   localparam int unsigned AW    = 9;
   localparam int unsigned FC    = 500;
   localparam int unsigned CW    = 12;
   localparam int unsigned DEPTH = 512;

   logic          clk = 1'b0;
   logic          reset, enable, ctl_ready, clear_flags;
   logic          mem_rd, jump, draw, frame_start, overrun, bad_list;
   logic [AW-1:0] mem_addr;
   logic [31:0]   mem_data;
   logic [11:0]   x, y;

   typedef struct {
      int unsigned cyc;
      logic        j;
      logic        d;
      logic [11:0] x;
      logic [11:0] y;
   } ev_t;

   logic [31:0] mem [DEPTH];
   int unsigned cyc = 0;
   int unsigned en_cyc;
   ev_t         ev_q[$];
   ev_t         exp_q[$];
   ev_t         mon_e;
   int unsigned fs_q[$];
   logic [AW:0] fsa_q[$];
   int unsigned exp_len;
   logic        exp_bad;
   int          n_assert = 0;
   int          n_fail   = 0;

   vector_list_sequencer #(.ADDR_W(AW), .FRAME_CYCLES(FC), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .enable(enable), .mem_rd(mem_rd), .mem_addr(mem_addr),
      .mem_data(mem_data), .ctl_ready(ctl_ready), .x(x), .y(y), .jump(jump), .draw(draw),
      .frame_start(frame_start), .overrun(overrun), .bad_list(bad_list), .clear_flags(clear_flags)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Synchronous RAM: data one cycle after the read strobe.
   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   always @(negedge clk) begin
      if (jump || draw) begin
         mon_e.cyc = cyc;
         mon_e.j   = jump;
         mon_e.d   = draw;
         mon_e.x   = x;
         mon_e.y   = y;
         ev_q.push_back(mon_e);
      end
      if (frame_start) begin
         fs_q.push_back(cyc);
         fsa_q.push_back({mem_rd, mem_addr});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] cmd(input logic [1:0] op, input logic [11:0] cx, input logic [11:0] cy);
      return {op, 2'b00, cx, 4'h0, cy};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walk the list as the spec describes it: 3 cycles per command, 2 per NOP/END, pulse at
   // the third cycle of a command; a list without END stops after the last word.
   task automatic model_frame();
      int unsigned t;
      logic [31:0] w;
      logic        found_end;
      ev_t         e;
      exp_q.delete();
      t = 0;
      found_end = 1'b0;
      for (int a = 0; a < int'(DEPTH); a++) begin
         w = mem[a];
         if (w[31:30] == 2'b10) begin
            t += 2;
            found_end = 1'b1;
            break;
         end
         if (w[31:30] == 2'b11) begin
            t += 2;
         end else begin
            e.cyc = t + 2;
            e.j   = (w[31:30] == 2'b00);
            e.d   = (w[31:30] == 2'b01);
            e.x   = w[27:16];
            e.y   = w[11:0];
            exp_q.push_back(e);
            t += 3;
         end
      end
      exp_len = t;
      exp_bad = !found_end;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      ctl_ready = 1'b1;
      clear_flags = 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = cmd(2'b10, 12'd0, 12'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      ev_q.delete();
      fs_q.delete();
      fsa_q.delete();
   endtask

   task automatic start_run();
      en_cyc = cyc;
      enable = 1'b1;
   endtask

   task automatic wait_fs(input int n, input int budget);
      int b;
      b = budget;
      while (fs_q.size() < n && b > 0) begin
         @(negedge clk);
         b--;
      end
   endtask

   task automatic check_frames(input int nf, input string tag);
      int unsigned period;
      ev_t         got;
      model_frame();
      period = (exp_len > FC) ? exp_len : FC;
      wait_fs(nf + 1, (nf + 1) * int'(period + 4) + 20);
      chk({tag, "_frames"}, 64'(fs_q.size() >= nf + 1), 64'(1));
      if (fs_q.size() < nf + 1) return;
      for (int k = 0; k < nf; k++) begin
         chk({tag, "_period"}, 64'(fs_q[k+1] - fs_q[k]), 64'(period));
         chk({tag, "_start_addr"}, 64'(fsa_q[k]), 64'({1'b1, {AW{1'b0}}}));
         foreach (exp_q[i]) begin
            if (ev_q.size() == 0) begin
               got.cyc = 32'hFFFF_FFFF;
               got.j = 1'b0; got.d = 1'b0; got.x = '0; got.y = '0;
            end else begin
               got = ev_q.pop_front();
            end
            chk({tag, "_event"},
                64'({32'(got.cyc - fs_q[k]), got.j, got.d, got.x, got.y}),
                64'({32'(exp_q[i].cyc), exp_q[i].j, exp_q[i].d, exp_q[i].x, exp_q[i].y}));
         end
         if (ev_q.size() > 0) chk({tag, "_no_extra"}, 64'(ev_q[0].cyc >= fs_q[k+1]), 64'(1));
      end
      chk({tag, "_overrun"}, 64'(overrun), 64'(exp_len > FC));
      chk({tag, "_bad_list"}, 64'(bad_list), 64'(exp_bad));
   endtask

   initial begin
      logic [31:0] w;
      int          b, n, nd;

      // Reset values
      reset = 1'b1; enable = 1'b0; ctl_ready = 1'b1; clear_flags = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mem_rd", 64'(mem_rd), 64'(0));
      chk("rst_mem_addr", 64'(mem_addr), 64'(0));
      chk("rst_xy", 64'({x, y}), 64'(0));
      chk("rst_jump", 64'(jump), 64'(0));
      chk("rst_draw", 64'(draw), 64'(0));
      chk("rst_frame_start", 64'(frame_start), 64'(0));
      chk("rst_flags", 64'({overrun, bad_list}), 64'(0));

      // Single frame: JUMP(100,200), DRAW(4095,0), END
      do_reset();
      mem[0] = cmd(2'b00, 12'd100, 12'd200);
      mem[1] = cmd(2'b01, 12'd4095, 12'd0);
      start_run();
      wait_fs(2, 600);
      chk("single_first_start", 64'(fs_q.size() > 0 ? fs_q[0] : 0), 64'(en_cyc + 1));
      chk("single_jump", 64'(ev_q.size() > 0 ? {ev_q[0].j, ev_q[0].d, ev_q[0].x, ev_q[0].y} : 26'h0),
          64'({1'b1, 1'b0, 12'd100, 12'd200}));
      chk("single_draw", 64'(ev_q.size() > 1 ? {ev_q[1].j, ev_q[1].d, ev_q[1].x, ev_q[1].y} : 26'h0),
          64'({1'b0, 1'b1, 12'd4095, 12'd0}));
      check_frames(2, "single");

      // Ready backpressure for 40 cycles after the jump
      do_reset();
      mem[0] = cmd(2'b00, 12'd12, 12'd34);
      mem[1] = cmd(2'b01, 12'd567, 12'd890);
      start_run();
      b = 50;
      while (jump !== 1'b1 && b > 0) begin
         @(negedge clk);
         b--;
      end
      chk("bp_jump_seen", 64'(jump), 64'(1));
      @(posedge clk);
      #1 ctl_ready = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         chk("bp_held", 64'({jump, draw}), 64'(0));
         if (i >= 3) chk("bp_xy_stable", 64'({x, y}), 64'({12'd567, 12'd890}));
      end
      @(posedge clk);
      #1 ctl_ready = 1'b1;
      @(negedge clk);
      chk("bp_draw", 64'({draw, x, y}), 64'({1'b1, 12'd567, 12'd890}));
      wait_fs(2, 600);
      chk("bp_period", 64'(fs_q.size() > 1 ? fs_q[1] - fs_q[0] : 0), 64'(FC));
      nd = 0;
      foreach (ev_q[i]) if (ev_q[i].d) nd++;
      chk("bp_draw_count", 64'(nd), 64'(1));
      chk("bp_event_count", 64'(ev_q.size()), 64'(2));

      // NOP skip
      do_reset();
      mem[0] = cmd(2'b11, 12'd1, 12'd1);
      mem[1] = cmd(2'b11, 12'd2, 12'd2);
      mem[2] = cmd(2'b01, 12'd7, 12'd9);
      start_run();
      check_frames(2, "nop");

      // Exact fit: list length equals the frame period, no overrun
      do_reset();
      for (int i = 0; i < 166; i++) mem[i] = cmd(2'b01, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      start_run();
      check_frames(2, "fit");

      // One command too long: overrun
      do_reset();
      for (int i = 0; i < 167; i++) mem[i] = cmd(2'b01, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      start_run();
      check_frames(1, "over1");

      // Long list: overrun, restart right after END, then clear_flags
      do_reset();
      for (int i = 0; i < 300; i++) mem[i] = cmd(2'b01, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      start_run();
      check_frames(1, "ovr");
      clear_flags = 1'b1;
      @(negedge clk);
      clear_flags = 1'b0;
      chk("ovr_cleared", 64'(overrun), 64'(0));

      // Missing END: every word a DRAW, address wraps
      do_reset();
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = cmd(2'b01, 12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)));
      start_run();
      repeat (100) @(negedge clk);
      chk("wrap_bad_early", 64'(bad_list), 64'(0));
      check_frames(1, "wrap");

      // Random lists with ignored bits set
      for (int r = 0; r < 3; r++) begin
         do_reset();
         n = int'($urandom_range(1, 60));
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            case ($urandom_range(0, 2))
               0:       w[31:30] = 2'b00;
               1:       w[31:30] = 2'b01;
               default: w[31:30] = 2'b11;
            endcase
            mem[i] = w;
         end
         start_run();
         check_frames(2, "rand");
      end

      // Enable dropped mid-frame: list completes, then idle
      do_reset();
      for (int i = 0; i < 20; i++) mem[i] = cmd(2'b01, 12'(i), 12'(i * 3));
      start_run();
      repeat (10) @(negedge clk);
      enable = 1'b0;
      repeat (1200) @(negedge clk);
      chk("en_one_frame", 64'(fs_q.size()), 64'(1));
      chk("en_all_cmds", 64'(ev_q.size()), 64'(20));
      chk("en_idle", 64'(mem_rd), 64'(0));

      // Reset while waiting in ISSUE
      do_reset();
      mem[0] = cmd(2'b00, 12'd321, 12'd654);
      ctl_ready = 1'b0;
      start_run();
      repeat (8) @(negedge clk);
      chk("rsti_latched", 64'({jump, x, y}), 64'({1'b0, 12'd321, 12'd654}));
      reset = 1'b1;
      ctl_ready = 1'b1;
      #1 chk("rsti_no_pulse", 64'({jump, draw}), 64'(0));
      @(negedge clk);
      chk("rsti_outputs", 64'({mem_rd, mem_addr, x, y, jump, draw, frame_start, overrun, bad_list}), 64'(0));
      reset = 1'b0;
      enable = 1'b0;
      repeat (2) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vector_list_sequencer.md
Name: vector_list_sequencer

Overview:
- Walks a display list in synchronous RAM and drives the vector `control` block's jump/draw command interface, one command per `ready`.
- Repeats the list every frame and paces frames to a fixed refresh period.
- Sits between the host-written display-list RAM and `control`; owns frame timing and list-error reporting.

Parameters:
- ADDR_W, 10, display-list address width (words).
- FRAME_CYCLES, 833333, minimum clk cycles per frame (60 Hz at 50 MHz).
- CNT_W, 20, frame timer width; must satisfy 2^CNT_W > FRAME_CYCLES.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  run sequencing; sampled in IDLE and at frame boundaries
- mem_rd  out  1  RAM read strobe
- mem_addr  out  ADDR_W (ADDR_W+1 with option)  RAM word address
- mem_data  in  32  RAM read data, valid exactly 1 cycle after mem_rd
- ctl_ready  in  1  `control` ready (combinational from `control`)
- x  out  12  target X to `control`
- y  out  12  target Y to `control`
- jump  out  1  one-cycle jump command
- draw  out  1  one-cycle draw command
- frame_start  out  1  one-cycle pulse at each frame restart
- overrun  out  1  sticky: list ran longer than FRAME_CYCLES
- bad_list  out  1  sticky: address wrapped with no END
- clear_flags  in  1  clears overrun and bad_list

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous and active-high.
- Reset values: all outputs 0. State IDLE. Address 0. Timer 0.
- Command word fields:
  - [31:30] opcode: 00 JUMP, 01 DRAW, 10 END, 11 NOP.
  - [27:16] X. [11:0] Y.
  - Other bits ignored.
- State machine IDLE -> FETCH -> DATA -> ISSUE -> FETCH ... -> FRAME_WAIT -> FETCH:
  - IDLE: when enable=1, pulse frame_start, clear timer, set address 0, go to FETCH.
  - FETCH: assert mem_rd for 1 cycle with the current address; go to DATA.
  - DATA: register mem_data.
    - NOP: address+1, go to FETCH.
    - END: go to FRAME_WAIT.
    - JUMP or DRAW: go to ISSUE.
  - ISSUE: x and y hold the latched command. Wait for ctl_ready=1. In that cycle pulse jump or draw for exactly 1 cycle, then address+1 and go to FETCH.
    - x and y stay stable until the next command is latched; `control` samples them while busy.
  - Minimum spacing: at least 3 cycles between successive jump/draw pulses. This guarantees `control` has deasserted ready before it is resampled.
  - FRAME_WAIT: wait until timer >= FRAME_CYCLES-1, then restart.
    - Restart = timer to 0, frame_start pulse, address 0, go to FETCH.
    - If enable=0 at restart, go to IDLE instead, with no frame_start.
- Frame timer:
  - Increments every cycle outside IDLE; saturates at all-ones.
  - Reaching FRAME_CYCLES before END is latched sets overrun. That frame then restarts the cycle after END.
- Address wrap: if the address increments from 2^ADDR_W-1, set bad_list and treat it as END for that frame.
- enable deasserted mid-frame: the frame completes through END/FRAME_WAIT, then IDLE. Commands are never truncated.
- clear_flags: clears both sticky flags. If a set condition occurs in the same cycle, set wins.
- reset mid-command: abort immediately to reset values. Any pulse in flight is dropped; `control` is reset by the same signal.

Optional Feature:
- Macro: VECLIST_DOUBLE_BUFFER_EN.
- Defined:
  - Adds input `bank_swap_req` (1) and output `bank_active` (1).
  - mem_addr becomes ADDR_W+1 bits, MSB = bank_active.
  - A swap request is held pending until the next restart. At restart, bank_active toggles, the pending request clears, and the frame_start pulse accompanies the new bank.
  - A request arriving in the restart cycle is deferred to the following frame.
- Undefined: single bank, no extra ports, mem_addr is ADDR_W bits.

Test Plan:
- Single frame:
  - Stimulus: list = JUMP(100,200), DRAW(4095,0), END; FRAME_CYCLES=500; ctl_ready held 1.
  - Required: jump then draw, each 1 cycle, x/y correct; frame_start at cycle 0 and again at 500.
- Ready backpressure:
  - Stimulus: ctl_ready low for 40 cycles after jump.
  - Required: draw held off until ready returns; exactly one draw pulse; x/y stable throughout.
- NOP skip:
  - Stimulus: NOP, NOP, DRAW, END.
  - Required: only one draw pulse; NOPs produce no jump/draw.
- Overrun:
  - Stimulus: 300 DRAWs, FRAME_CYCLES=200.
  - Required: overrun set; restart the cycle after END.
  - Stimulus: clear_flags pulse.
  - Required: overrun clears.
- Missing END:
  - Stimulus: ADDR_W=4, all 16 words DRAW.
  - Required: bad_list set after word 15; restart at address 0.
- Reset and enable:
  - Stimulus: reset in ISSUE mid-frame.
  - Required: all outputs 0 next cycle.
  - Stimulus: enable=0 mid-frame.
  - Required: finishes to END, then IDLE with no further frame_start.
